// File: rtl/msk_aes_mixcolumns_stream.sv
// Masked AES forward MixColumns, one column per transfer, 2-entry elastic output buffer.
// Optional final-round pass-through enabled by defining MSK_MC_BYPASS_EN.
module msk_aes_mixcolumns_stream #(
    parameter int unsigned d = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*d-1:0]   in_b0,
    input  logic [8*d-1:0]   in_b1,
    input  logic [8*d-1:0]   in_b2,
    input  logic [8*d-1:0]   in_b3,
`ifdef MSK_MC_BYPASS_EN
    input  logic             in_bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*d-1:0]   out_a0,
    output logic [8*d-1:0]   out_a1,
    output logic [8*d-1:0]   out_a2,
    output logic [8*d-1:0]   out_a3,
    output logic [1:0]       out_col,
    output logic             out_last
);

    localparam int unsigned W  = 8 * d;
    localparam int unsigned EW = 4 * W;

    logic [7:0]    sb [4];
    logic [7:0]    sa [4];
    logic [EW-1:0] mc_word;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] mem [2];
    logic [EW-1:0] head;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    col;
    logic          push;
    logic          pop;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Each share is gathered into a byte, transformed alone, and scattered back.
    always_comb begin
        mc_word = '0;
        sb      = '{default: '0};
        sa      = '{default: '0};
        for (int s = 0; s < int'(d); s++) begin
            for (int i = 0; i < 8; i++) begin
                sb[0][i] = in_b0[int'(d)*i+s];
                sb[1][i] = in_b1[int'(d)*i+s];
                sb[2][i] = in_b2[int'(d)*i+s];
                sb[3][i] = in_b3[int'(d)*i+s];
            end
            sa[0] = xt(sb[0]) ^ xt(sb[1]) ^ sb[1] ^ sb[2] ^ sb[3];
            sa[1] = sb[0] ^ xt(sb[1]) ^ xt(sb[2]) ^ sb[2] ^ sb[3];
            sa[2] = sb[0] ^ sb[1] ^ xt(sb[2]) ^ xt(sb[3]) ^ sb[3];
            sa[3] = xt(sb[0]) ^ sb[0] ^ sb[1] ^ sb[2] ^ xt(sb[3]);
            for (int i = 0; i < 8; i++) begin
                mc_word[int'(d)*i+s]         = sa[0][i];
                mc_word[int'(W)+int'(d)*i+s]   = sa[1][i];
                mc_word[2*int'(W)+int'(d)*i+s] = sa[2][i];
                mc_word[3*int'(W)+int'(d)*i+s] = sa[3][i];
            end
        end
    end

`ifdef MSK_MC_BYPASS_EN
    assign wr_word = in_bypass ? {in_b3, in_b2, in_b1, in_b0} : mc_word;
`else
    assign wr_word = mc_word;
`endif

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Buffer pointers, occupancy and column position within the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            col    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                col    <= col + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign head      = mem[rd_ptr];
    assign out_a0    = head[W-1:0];
    assign out_a1    = head[2*W-1:W];
    assign out_a2    = head[3*W-1:2*W];
    assign out_a3    = head[4*W-1:3*W];
    assign out_col   = col;
    assign out_last  = (col == 2'd3);

endmodule

// File: tb/tb_msk_aes_mixcolumns_stream.sv
// Directed bench for msk_aes_mixcolumns_stream (d=2); bypass vectors run when MSK_MC_BYPASS_EN is defined.
module tb_msk_aes_mixcolumns_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_b0, in_b1, in_b2, in_b3;
`ifdef MSK_MC_BYPASS_EN
    logic        in_bypass;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a0, out_a1, out_a2, out_a3;
    logic [1:0]  out_col;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] s_in  [4];
    logic [31:0] s_out [4];

    always #5 clk = ~clk;

    msk_aes_mixcolumns_stream #(.d(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b0     (in_b0),
        .in_b1     (in_b1),
        .in_b2     (in_b2),
        .in_b3     (in_b3),
`ifdef MSK_MC_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a0    (out_a0),
        .out_a1    (out_a1),
        .out_a2    (out_a2),
        .out_a3    (out_a3),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v[2*i]   = s0[i];
            v[2*i+1] = s1[i];
        end
        return v;
    endfunction

    function automatic logic [7:0] share(input logic [15:0] v, input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = v[2*i+s];
        return b;
    endfunction

    function automatic logic [31:0] share_word(input int s);
        return {share(out_a0, s), share(out_a1, s), share(out_a2, s), share(out_a3, s)};
    endfunction

    function automatic logic [31:0] out_word();
        return share_word(0) ^ share_word(1);
    endfunction

    task automatic drive(input logic [31:0] data, input logic [31:0] mask);
        logic [31:0] m1;
        m1       = data ^ mask;
        in_b0    = enc(mask[31:24], m1[31:24]);
        in_b1    = enc(mask[23:16], m1[23:16]);
        in_b2    = enc(mask[15:8],  m1[15:8]);
        in_b3    = enc(mask[7:0],   m1[7:0]);
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        s_in[0] = 32'h01010101; s_out[0] = 32'h01010101;
        s_in[1] = 32'hc6c6c6c6; s_out[1] = 32'hc6c6c6c6;
        s_in[2] = 32'hd4d4d4d5; s_out[2] = 32'hd5d5d7d6;
        s_in[3] = 32'h2d26314c; s_out[3] = 32'h4d7ebdf8;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_b0 = '0; in_b1 = '0; in_b2 = '0; in_b3 = '0;
`ifdef MSK_MC_BYPASS_EN
        in_bypass = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_col",   32'(out_col),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_a",     {out_a0, out_a1} | {out_a2, out_a3}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Single unmasked-equivalent column, 1-cycle latency.
        out_ready = 1'b1;
        drive(32'hdb135345, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  out_word(),     32'h8e4da1bc);
        check("t1_col",   32'(out_col),   32'd0);
        @(negedge clk);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Masked column: each share transformed on its own.
        do_reset();
        out_ready = 1'b1;
        drive(32'hf20a225c, 32'ha53c7e11);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_data",   out_word(),    32'h9fdc589d);
        check("t2_share0", share_word(0), 32'h7a4e5694);
        check("t2_share1", share_word(1), 32'he5920e09);

        // Back-to-back stream of a full state.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check($sformatf("t3_valid%0d", i-1), 32'(out_valid), 32'd1);
                check($sformatf("t3_data%0d", i-1),  out_word(),     s_out[i-1]);
                check($sformatf("t3_col%0d", i-1),   32'(out_col),   32'(i-1));
                check($sformatf("t3_last%0d", i-1),  32'(out_last),  32'(i == 4));
            end
            if (i < 4) begin
                check($sformatf("t3_ready%0d", i), 32'(in_ready), 32'd1);
                drive(s_in[i], 32'h5a5a5a5a);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_wrap",  32'(out_col),   32'd0);

        // Backpressure: two absorbed, third held off, then drained in order.
        do_reset();
        out_ready = 1'b0;
        check("t4_rdy0", 32'(in_ready), 32'd1);
        drive(s_in[0], 32'h0f0f0f0f);
        @(negedge clk);
        check("t4_rdy1", 32'(in_ready), 32'd1);
        drive(s_in[1], 32'h33333333);
        @(negedge clk);
        check("t4_full",  32'(in_ready), 32'd0);
        check("t4_head",  out_word(),    s_out[0]);
        drive(s_in[2], 32'hc3c3c3c3);
        @(negedge clk);
        check("t4_full2", 32'(in_ready), 32'd0);
        check("t4_hold",  out_word(),    s_out[0]);
        check("t4_holdc", 32'(out_col),  32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_rdy2",  32'(in_ready), 32'd1);
        check("t4_out1",  out_word(),    s_out[1]);
        check("t4_col1",  32'(out_col),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_out2",  out_word(),    s_out[2]);
        check("t4_col2",  32'(out_col),  32'd2);
        @(negedge clk);
        check("t4_empty", 32'(out_valid), 32'd0);
        check("t4_col3",  32'(out_col),   32'd3);

        // Reset mid-state with one column buffered.
        do_reset();
        out_ready = 1'b1;
        drive(s_in[0], 32'h0);
        @(negedge clk);
        drive(s_in[1], 32'h0);
        @(negedge clk);
        drive(s_in[2], 32'h0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_col",   32'(out_col),   32'd2);
        check("t5_pre_data",  out_word(),     s_out[2]);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_col",   32'(out_col),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(s_in[3], 32'h96969696);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_data", out_word(),   s_out[3]);
        check("t5_col",  32'(out_col), 32'd0);
        check("t5_last", 32'(out_last), 32'd0);

`ifdef MSK_MC_BYPASS_EN
        // Final-round pass-through followed by a normal column.
        do_reset();
        out_ready = 1'b1;
        in_bypass = 1'b1;
        drive(32'hdb135345, 32'h12345678);
        @(negedge clk);
        check("t6_bypass", out_word(), 32'hdb135345);
        in_bypass = 1'b0;
        drive(32'hdb135345, 32'h12345678);
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_normal", out_word(), 32'h8e4da1bc);
        check("t6_col",    32'(out_col), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
